// File: rtl/wb_arbiter_pkg.sv
// rtl/wb_arbiter_pkg.sv - shared types, defaults and helpers for the write-back arbiter
package wb_arbiter_pkg;

   localparam int WB_XLEN          = 32;
   localparam int DEF_DEPTH        = 2;
   localparam int DEF_STARVE_LIMIT = 4;

   typedef struct packed {
      logic [4:0]         rd;
      logic [WB_XLEN-1:0] data;
   } wb_req_t;

   function automatic logic [31:0] rd_onehot(input logic [4:0] rd);
      rd_onehot = 32'd1 << rd;
   endfunction

endpackage

// File: rtl/wb_fifo.sv
// rtl/wb_fifo.sv - small in-order FIFO of write-back requests with per-entry visibility
module wb_fifo
   import wb_arbiter_pkg::*;
#(
   parameter type entry_t = wb_req_t,
   parameter int  DEPTH   = DEF_DEPTH
) (
   input  logic                   clk,
   input  logic                   arst_n,
   input  logic                   push,
   input  entry_t                 push_entry,
   input  logic                   pop,
   output logic                   full,
   output logic                   empty,
   output entry_t                 head,
   output logic [DEPTH-1:0]       valid,
   output entry_t [DEPTH-1:0]     entries
);

   localparam int AW = $clog2(DEPTH);

   entry_t [DEPTH-1:0] mem;
   logic [AW-1:0]      wr_ptr;
   logic [AW-1:0]      rd_ptr;
   logic [AW:0]        count;

   // Payload storage carries no reset; validity is tracked separately.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= push_entry;
   end

   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         valid  <= '0;
      end else begin
         if (push) begin
            valid[wr_ptr] <= 1'b1;
            wr_ptr        <= wr_ptr + 1'b1;
         end
         if (pop) begin
            valid[rd_ptr] <= 1'b0;
            rd_ptr        <= rd_ptr + 1'b1;
         end
         count <= count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
      end
   end

   assign full    = (count == (AW+1)'(DEPTH));
   assign empty   = (count == '0);
   assign head    = mem[rd_ptr];
   assign entries = mem;

endmodule

// File: rtl/wb_arbiter.sv
// rtl/wb_arbiter.sv - register-file write-port arbiter between pipeline write-back and MDU results
module wb_arbiter
   import wb_arbiter_pkg::*;
#(
   parameter int XLEN         = 32,
   parameter int DEPTH        = DEF_DEPTH,
   parameter int STARVE_LIMIT = DEF_STARVE_LIMIT
) (
   input  logic            clk,
   input  logic            arst_n,
   input  logic            pipe_wb_en,
   input  logic [4:0]      pipe_rd,
   input  logic [XLEN-1:0] pipe_wb_data,
   output logic            pipe_stall,
   input  logic            mdu_valid,
   input  logic [4:0]      mdu_rd,
   input  logic [XLEN-1:0] mdu_data,
   output logic            mdu_ready,
   output logic            rf_we,
   output logic [4:0]      rf_waddr,
   output logic [XLEN-1:0] rf_wdata,
   output logic [31:0]     pending_mask
);

   typedef struct packed {
      logic [4:0]      rd;
      logic [XLEN-1:0] data;
   } req_t;

   localparam int CW = $clog2(STARVE_LIMIT + 1);

   logic             pipe_req;
   logic             push;
   logic             fifo_grant;
   logic             full;
   logic             empty;
   req_t             push_entry;
   req_t             head;
   logic [DEPTH-1:0] valid;
   req_t [DEPTH-1:0] entries;
   logic [CW-1:0]    starve_cnt;

   assign pipe_req   = pipe_wb_en && (pipe_rd != 5'd0);
   assign mdu_ready  = !full;
   // Results aimed at x0 are consumed but never buffered.
   assign push       = mdu_valid && !full && (mdu_rd != 5'd0);
   assign push_entry = '{rd: mdu_rd, data: mdu_data};
   assign fifo_grant = !empty && (!pipe_req || starve_cnt == CW'(STARVE_LIMIT));

   wb_fifo #(
      .entry_t (req_t),
      .DEPTH   (DEPTH)
   ) u_fifo (
      .clk        (clk),
      .arst_n     (arst_n),
      .push       (push),
      .push_entry (push_entry),
      .pop        (fifo_grant),
      .full       (full),
      .empty      (empty),
      .head       (head),
      .valid      (valid),
      .entries    (entries)
   );

   always_comb begin
      rf_we      = 1'b0;
      rf_waddr   = 5'd0;
      rf_wdata   = '0;
      pipe_stall = 1'b0;
      if (fifo_grant) begin
         rf_we      = 1'b1;
         rf_waddr   = head.rd;
         rf_wdata   = head.data;
         pipe_stall = pipe_req;
      end else if (pipe_req) begin
         rf_we    = 1'b1;
         rf_waddr = pipe_rd;
         rf_wdata = pipe_wb_data;
      end
   end

   always_comb begin
      pending_mask = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (valid[i]) pending_mask |= rd_onehot(entries[i].rd);
      end
   end

   // Counts pipe wins while results wait; saturation triggers the forced drain.
   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         starve_cnt <= '0;
      end else if (empty || fifo_grant) begin
         starve_cnt <= '0;
      end else if (starve_cnt != CW'(STARVE_LIMIT)) begin
         starve_cnt <= starve_cnt + 1'b1;
      end
   end

endmodule

// File: tb/tb_wb_arbiter.sv
// tb/tb_wb_arbiter.sv - directed self-checking bench for wb_arbiter
module tb_wb_arbiter;

   logic        clk = 1'b0;
   logic        arst_n;
   logic        pipe_wb_en;
   logic [4:0]  pipe_rd;
   logic [31:0] pipe_wb_data;
   logic        pipe_stall;
   logic        mdu_valid;
   logic [4:0]  mdu_rd;
   logic [31:0] mdu_data;
   logic        mdu_ready;
   logic        rf_we;
   logic [4:0]  rf_waddr;
   logic [31:0] rf_wdata;
   logic [31:0] pending_mask;

   int total = 0;
   int bad   = 0;

   wb_arbiter #(.XLEN(32), .DEPTH(2), .STARVE_LIMIT(4)) dut (
      .clk          (clk),
      .arst_n       (arst_n),
      .pipe_wb_en   (pipe_wb_en),
      .pipe_rd      (pipe_rd),
      .pipe_wb_data (pipe_wb_data),
      .pipe_stall   (pipe_stall),
      .mdu_valid    (mdu_valid),
      .mdu_rd       (mdu_rd),
      .mdu_data     (mdu_data),
      .mdu_ready    (mdu_ready),
      .rf_we        (rf_we),
      .rf_waddr     (rf_waddr),
      .rf_wdata     (rf_wdata),
      .pending_mask (pending_mask)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      #1;
      total++; if (rf_we !== 1'b0) begin bad++; $display("FAIL reset_rf_we got=%b want=0", rf_we); end
      total++; if (rf_waddr !== 5'd0) begin bad++; $display("FAIL reset_waddr got=%0d want=0", rf_waddr); end
      total++; if (rf_wdata !== 32'd0) begin bad++; $display("FAIL reset_wdata got=%h want=0", rf_wdata); end
      total++; if (mdu_ready !== 1'b1) begin bad++; $display("FAIL reset_mdu_ready got=%b want=1", mdu_ready); end
      total++; if (pending_mask !== 32'd0) begin bad++; $display("FAIL reset_mask got=%h want=0", pending_mask); end
      total++; if (pipe_stall !== 1'b0) begin bad++; $display("FAIL reset_stall got=%b want=0", pipe_stall); end
      tick();
   endtask

   task automatic test_pipe_write();
      pipe_wb_en = 1'b1; pipe_rd = 5'd5; pipe_wb_data = 32'hA5A5_0001;
      #1;
      total++; if (rf_we !== 1'b1) begin bad++; $display("FAIL pipe_we got=%b want=1", rf_we); end
      total++; if (rf_waddr !== 5'd5) begin bad++; $display("FAIL pipe_waddr got=%0d want=5", rf_waddr); end
      total++; if (rf_wdata !== 32'hA5A5_0001) begin bad++; $display("FAIL pipe_wdata got=%h want=a5a50001", rf_wdata); end
      total++; if (pipe_stall !== 1'b0) begin bad++; $display("FAIL pipe_stall got=%b want=0", pipe_stall); end
      tick();
      pipe_wb_en = 1'b0; pipe_rd = 5'd0; pipe_wb_data = 32'd0;
      #1;
   endtask

   task automatic test_mdu_single();
      mdu_valid = 1'b1; mdu_rd = 5'd7; mdu_data = 32'h1234;
      #1;
      total++; if (mdu_ready !== 1'b1) begin bad++; $display("FAIL single_ready got=%b want=1", mdu_ready); end
      total++; if (rf_we !== 1'b0) begin bad++; $display("FAIL single_no_bypass got=%b want=0", rf_we); end
      total++; if (pending_mask !== 32'd0) begin bad++; $display("FAIL single_mask_n got=%h want=0", pending_mask); end
      tick();
      mdu_valid = 1'b0; mdu_rd = 5'd0; mdu_data = 32'd0;
      #1;
      total++; if (pending_mask !== 32'h0000_0080) begin bad++; $display("FAIL single_mask_n1 got=%h want=00000080", pending_mask); end
      total++; if ({rf_we, rf_waddr} !== {1'b1, 5'd7}) begin bad++; $display("FAIL single_write got=%b/%0d want=1/7", rf_we, rf_waddr); end
      total++; if (rf_wdata !== 32'h1234) begin bad++; $display("FAIL single_wdata got=%h want=00001234", rf_wdata); end
      tick();
      total++; if (pending_mask !== 32'd0) begin bad++; $display("FAIL single_mask_n2 got=%h want=0", pending_mask); end
      total++; if (rf_we !== 1'b0) begin bad++; $display("FAIL single_idle got=%b want=0", rf_we); end
   endtask

   task automatic test_forced_drain();
      pipe_wb_en = 1'b1; pipe_rd = 5'd10; pipe_wb_data = 32'h100;
      mdu_valid = 1'b1; mdu_rd = 5'd3; mdu_data = 32'h33;
      #1;
      total++; if ({rf_we, rf_waddr, pipe_stall} !== {1'b1, 5'd10, 1'b0}) begin bad++; $display("FAIL drain_c0 got=%b/%0d/%b want=1/10/0", rf_we, rf_waddr, pipe_stall); end
      tick();
      mdu_valid = 1'b0; mdu_rd = 5'd0; mdu_data = 32'd0;
      for (int i = 1; i <= 4; i++) begin
         pipe_wb_data = 32'h100 + i;
         #1;
         total++; if ({rf_waddr, pipe_stall} !== {5'd10, 1'b0}) begin bad++; $display("FAIL drain_pipe%0d got=%0d/%b want=10/0", i, rf_waddr, pipe_stall); end
         total++; if (rf_wdata !== 32'h100 + i) begin bad++; $display("FAIL drain_pdata%0d got=%h want=%h", i, rf_wdata, 32'h100 + i); end
         total++; if (pending_mask !== 32'h0000_0008) begin bad++; $display("FAIL drain_mask%0d got=%h want=00000008", i, pending_mask); end
         tick();
      end
      #1;
      total++; if ({rf_we, rf_waddr, pipe_stall} !== {1'b1, 5'd3, 1'b1}) begin bad++; $display("FAIL drain_force got=%b/%0d/%b want=1/3/1", rf_we, rf_waddr, pipe_stall); end
      total++; if (rf_wdata !== 32'h33) begin bad++; $display("FAIL drain_fdata got=%h want=00000033", rf_wdata); end
      tick();
      total++; if ({rf_waddr, pipe_stall} !== {5'd10, 1'b0}) begin bad++; $display("FAIL drain_resume got=%0d/%b want=10/0", rf_waddr, pipe_stall); end
      total++; if (pending_mask !== 32'd0) begin bad++; $display("FAIL drain_mask_clr got=%h want=0", pending_mask); end
      tick();
      pipe_wb_en = 1'b0; pipe_rd = 5'd0; pipe_wb_data = 32'd0;
      #1;
   endtask

   task automatic test_back_to_back();
      pipe_wb_en = 1'b1; pipe_rd = 5'd9; pipe_wb_data = 32'h99;
      mdu_valid = 1'b1; mdu_rd = 5'd11; mdu_data = 32'hA1;
      #1;
      total++; if (mdu_ready !== 1'b1) begin bad++; $display("FAIL b2b_rdy0 got=%b want=1", mdu_ready); end
      tick();
      mdu_rd = 5'd12; mdu_data = 32'hB2;
      #1;
      total++; if (mdu_ready !== 1'b1) begin bad++; $display("FAIL b2b_rdy1 got=%b want=1", mdu_ready); end
      total++; if (rf_waddr !== 5'd9) begin bad++; $display("FAIL b2b_pipe1 got=%0d want=9", rf_waddr); end
      tick();
      mdu_rd = 5'd13; mdu_data = 32'hC3;
      for (int c = 2; c <= 4; c++) begin
         #1;
         total++; if (mdu_ready !== 1'b0) begin bad++; $display("FAIL b2b_full%0d got=%b want=0", c, mdu_ready); end
         total++; if ({rf_waddr, pipe_stall} !== {5'd9, 1'b0}) begin bad++; $display("FAIL b2b_pipe%0d got=%0d/%b want=9/0", c, rf_waddr, pipe_stall); end
         total++; if (pending_mask !== 32'h0000_1800) begin bad++; $display("FAIL b2b_mask%0d got=%h want=00001800", c, pending_mask); end
         tick();
      end
      #1;
      total++; if (mdu_ready !== 1'b0) begin bad++; $display("FAIL b2b_full_pop got=%b want=0", mdu_ready); end
      total++; if ({rf_waddr, rf_wdata, pipe_stall} !== {5'd11, 32'hA1, 1'b1}) begin bad++; $display("FAIL b2b_popA got=%0d/%h/%b want=11/a1/1", rf_waddr, rf_wdata, pipe_stall); end
      tick();
      pipe_wb_en = 1'b0; pipe_rd = 5'd0; pipe_wb_data = 32'd0;
      #1;
      total++; if (mdu_ready !== 1'b1) begin bad++; $display("FAIL b2b_rdy_after_pop got=%b want=1", mdu_ready); end
      total++; if ({rf_we, rf_waddr, rf_wdata} !== {1'b1, 5'd12, 32'hB2}) begin bad++; $display("FAIL b2b_popB got=%b/%0d/%h want=1/12/b2", rf_we, rf_waddr, rf_wdata); end
      total++; if (pending_mask !== 32'h0000_1000) begin bad++; $display("FAIL b2b_maskB got=%h want=00001000", pending_mask); end
      tick();
      mdu_valid = 1'b0; mdu_rd = 5'd0; mdu_data = 32'd0;
      #1;
      total++; if ({rf_we, rf_waddr, rf_wdata} !== {1'b1, 5'd13, 32'hC3}) begin bad++; $display("FAIL b2b_popC got=%b/%0d/%h want=1/13/c3", rf_we, rf_waddr, rf_wdata); end
      total++; if (pending_mask !== 32'h0000_2000) begin bad++; $display("FAIL b2b_maskC got=%h want=00002000", pending_mask); end
      tick();
      total++; if ({rf_we, pending_mask} !== {1'b0, 32'd0}) begin bad++; $display("FAIL b2b_idle got=%b/%h want=0/0", rf_we, pending_mask); end
   endtask

   task automatic test_x0();
      pipe_wb_en = 1'b1; pipe_rd = 5'd0; pipe_wb_data = 32'hBEEF;
      mdu_valid = 1'b1; mdu_rd = 5'd0; mdu_data = 32'hDEAD;
      #1;
      total++; if (rf_we !== 1'b0) begin bad++; $display("FAIL x0_no_write got=%b want=0", rf_we); end
      total++; if (mdu_ready !== 1'b1) begin bad++; $display("FAIL x0_ready got=%b want=1", mdu_ready); end
      tick();
      pipe_wb_en = 1'b0; mdu_valid = 1'b0;
      #1;
      total++; if ({rf_we, pending_mask} !== {1'b0, 32'd0}) begin bad++; $display("FAIL x0_no_entry got=%b/%h want=0/0", rf_we, pending_mask); end
      tick();
      total++; if (rf_we !== 1'b0) begin bad++; $display("FAIL x0_still_empty got=%b want=0", rf_we); end
   endtask

   task automatic test_reset_mid();
      pipe_wb_en = 1'b1; pipe_rd = 5'd1; pipe_wb_data = 32'h1;
      mdu_valid = 1'b1; mdu_rd = 5'd20; mdu_data = 32'h2020;
      tick();
      mdu_valid = 1'b0; mdu_rd = 5'd0;
      #1;
      total++; if (pending_mask !== 32'h0010_0000) begin bad++; $display("FAIL mid_mask_set got=%h want=00100000", pending_mask); end
      arst_n = 1'b0;
      pipe_wb_en = 1'b0; pipe_rd = 5'd0; pipe_wb_data = 32'd0;
      #1;
      total++; if ({pending_mask, mdu_ready, rf_we} !== {32'd0, 1'b1, 1'b0}) begin bad++; $display("FAIL mid_flush got=%h/%b/%b want=0/1/0", pending_mask, mdu_ready, rf_we); end
      #1;
      arst_n = 1'b1;
      tick();
      total++; if ({rf_we, pending_mask} !== {1'b0, 32'd0}) begin bad++; $display("FAIL mid_after got=%b/%h want=0/0", rf_we, pending_mask); end
   endtask

   initial begin
      arst_n = 1'b0;
      pipe_wb_en = 1'b0; pipe_rd = 5'd0; pipe_wb_data = 32'd0;
      mdu_valid = 1'b0; mdu_rd = 5'd0; mdu_data = 32'd0;
      #12;
      arst_n = 1'b1;
      test_reset();
      test_pipe_write();
      test_mdu_single();
      test_forced_drain();
      test_back_to_back();
      test_x0();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
